// File: rtl/axi4_partition_rd_split_if.sv
// AXI4 read-channel bundle (AR + R) used on both sides of the read partitioner.
// Ports (signals):
//   arvalid/arready  AR handshake
//   arid/araddr/arlen  AR payload (IDW / AW / LW bits)
//   rvalid/rready    R handshake
//   rid/rdata/rresp/rlast  R payload (IDW / DW / 2 / 1 bits)
// Modports: master drives AR and rready; slave drives arready and the R payload.
interface axi4_partition_rd_split_if #(
  parameter int IDW = 4,
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int LW  = 8
);
  logic           arvalid;
  logic           arready;
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [LW-1:0]  arlen;
  logic           rvalid;
  logic           rready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;

  modport master (
    output arvalid, arid, araddr, arlen, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi4_partition_rd_split.sv
// AXI4 read partitioner: takes one INCR read burst at a time on the slave side,
// issues it as master-side sub-bursts of at most PSIZE beats (optionally also cut
// at 4KB boundaries), and reassembles the R stream so the client sees a single
// rlast per original burst with its original rid.
// Ports:
//   clock, rst        clock, asynchronous active-high reset
//   s                 slave-side AR/R bundle (IDSIZE-bit ids)
//   m                 master-side AR/R bundle (IDSIZE+4-bit ids = {s_arid, seq})
//   m_arsize          constant log2(DSIZE/8); burst type is INCR
//   err_rlast         sticky: a master rlast arrived with no sub-burst outstanding
//
// state | meaning
// IDLE  | accepting a new slave burst (s_arready high once out of reset)
// CALC  | sizing the next sub-burst; waits here while the tracker is full
// ISSUE | m_arvalid high with stable fields until m_arready
module axi4_partition_rd_split #(
  parameter int IDSIZE      = 4,
  parameter int ASIZE       = 32,
  parameter int DSIZE       = 64,
  parameter int LSIZE       = 8,
  parameter int PSIZE       = 16,
  parameter int OUTSTANDING = 4,
  parameter int SPLIT_4K    = 1
) (
  input  logic clock,
  input  logic rst,
  axi4_partition_rd_split_if.slave  s,
  axi4_partition_rd_split_if.master m,
  output logic [2:0] m_arsize,
  output logic       err_rlast
);
  localparam int BYTES = DSIZE / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int PW    = $clog2(OUTSTANDING);
  localparam int CW    = 14;

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;
  state_t state, state_nx;

  logic              rdy_en;
  logic [IDSIZE-1:0] id_q;
  logic [ASIZE-1:0]  addr_q;
  logic [LSIZE:0]    rem_q, sub_q;
  logic [3:0]        seq_q;
  logic              last_q;
  logic [ASIZE-1:0]  araddr_q;
  logic [LSIZE-1:0]  arlen_q;
  logic [IDSIZE+3:0] arid_q;

  logic [OUTSTANDING-1:0] trk_last;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW:0]            count;
  logic                   full, empty, push, pop, r_last_hs, s_hs;

  // Sub-burst sizing. The 4KB room counts the partially used first beat of an
  // unaligned start as a whole beat, so it is never zero.
  logic [11:0]    off_al;
  logic [CW-1:0]  room, limit, rem_x, ps_x, min1, sub_w;
  logic [LSIZE:0] sub;

  assign off_al = addr_q[11:0] & ~12'(BYTES - 1);
  assign room   = (CW'(4096) - CW'(off_al)) >> BSH;
  assign limit  = (SPLIT_4K != 0) ? room : '1;
  assign rem_x  = CW'(rem_q);
  assign ps_x   = CW'(PSIZE);
  assign min1   = (rem_x < ps_x) ? rem_x : ps_x;
  assign sub_w  = (min1 < limit) ? min1 : limit;
  assign sub    = (LSIZE+1)'(sub_w);

  assign full  = (count == (PW+1)'(OUTSTANDING));
  assign empty = (count == '0);
  assign s_hs  = s.arvalid & s.arready;
  assign push  = (state == ISSUE) & m.arready;
  assign r_last_hs = m.rvalid & s.rready & m.rlast;
  assign pop   = r_last_hs & ~empty;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s_hs) state_nx = CALC;
      CALC:    if (!full) state_nx = ISSUE;
      ISSUE:   if (m.arready) state_nx = last_q ? IDLE : CALC;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s.arready = 1'b0;
    m.arvalid = 1'b0;
    case (state)
      IDLE:    s.arready = rdy_en;
      ISSUE:   m.arvalid = 1'b1;
      default: ;
    endcase
  end

  // rdy_en keeps s_arready low for the first cycle after reset release.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rdy_en   <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      sub_q    <= '0;
      seq_q    <= '0;
      last_q   <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE: if (s_hs) begin
          id_q   <= s.arid;
          addr_q <= s.araddr;
          rem_q  <= {1'b0, s.arlen} + (LSIZE+1)'(1);
          seq_q  <= '0;
        end
        CALC: begin
          araddr_q <= addr_q;
          arlen_q  <= LSIZE'(sub - (LSIZE+1)'(1));
          arid_q   <= {id_q, seq_q};
          last_q   <= (rem_q == sub);
          sub_q    <= sub;
        end
        ISSUE: if (m.arready) begin
          addr_q <= addr_q + (ASIZE'(sub_q) << BSH);
          rem_q  <= rem_q - sub_q;
          seq_q  <= seq_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Tracker: one "last sub-burst of the slave burst" flag per issued AR. The
  // slave rid is recovered from m_rid, so only the flag needs storing.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      trk_last  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_rlast <= 1'b0;
    end else begin
      if (push) begin
        trk_last[wr_ptr] <= last_q;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
      if (r_last_hs && empty) err_rlast <= 1'b1;
    end
  end

  assign m.araddr = araddr_q;
  assign m.arlen  = arlen_q;
  assign m.arid   = arid_q;
  assign m_arsize = 3'(BSH);

  assign s.rvalid = m.rvalid;
  assign m.rready = s.rready;
  assign s.rdata  = m.rdata;
  assign s.rresp  = m.rresp;
  assign s.rid    = m.rid[IDSIZE+3:4];
  assign s.rlast  = m.rlast & ~empty & trk_last[rd_ptr];

  logic unused_seq_bits;
  assign unused_seq_bits = ^m.rid[3:0];
endmodule

// File: tb/tb_axi4_partition_rd_split.sv
module tb_axi4_partition_rd_split;
  localparam int IDSIZE = 4, ASIZE = 32, DSIZE = 64, LSIZE = 8, PSIZE = 16;
  localparam int MIDW = IDSIZE + 4;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  axi4_partition_rd_split_if #(.IDW(IDSIZE), .AW(ASIZE), .DW(DSIZE), .LW(LSIZE)) s_a(), s_b();
  axi4_partition_rd_split_if #(.IDW(MIDW),   .AW(ASIZE), .DW(DSIZE), .LW(LSIZE)) m_a(), m_b();
  logic [2:0] arsize_a, arsize_b;
  logic       err_a, err_b;

  axi4_partition_rd_split #(.IDSIZE(IDSIZE), .ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE),
    .PSIZE(PSIZE), .OUTSTANDING(4), .SPLIT_4K(1)) dut_a (
    .clock(clock), .rst(rst), .s(s_a), .m(m_a), .m_arsize(arsize_a), .err_rlast(err_a));

  axi4_partition_rd_split #(.IDSIZE(IDSIZE), .ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE),
    .PSIZE(PSIZE), .OUTSTANDING(2), .SPLIT_4K(0)) dut_b (
    .clock(clock), .rst(rst), .s(s_b), .m(m_b), .m_arsize(arsize_b), .err_rlast(err_b));

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [7:0] id; } ar_t;
  typedef struct { logic [3:0] id; int beats; } burst_t;

  ar_t    exp_ar_q[$], issued_a_q[$], log_a[$], issued_b_q[$], log_b[$];
  burst_t burst_q[$];
  int beat_cnt = 0, outst = 0;
  bit model_err = 0, mar_pending = 0, prev_stall_a = 0;
  int rbeats_a = 0, rlast_cnt_a = 0, rlast_at_a = 0, t_sar = 0, t_mar = 0, rlast_cnt_b = 0;
  logic [3:0] rlast_id_a = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference split: each sub-burst is the smallest of remaining beats, PSIZE,
  // and the beats left before the next 4KB page.
  task automatic model_split(input logic [3:0] id, input logic [31:0] addr, input int len);
    int rem = len + 1;
    longint a = addr;
    int seq = 0;
    while (rem > 0) begin
      int sub = (rem < PSIZE) ? rem : PSIZE;
      int room = (4096 - int'(a % 4096) + 7) / 8;
      ar_t e;
      if (room < sub) sub = room;
      e.addr = a[31:0];
      e.len  = 8'(sub - 1);
      e.id   = {id, 4'(seq)};
      exp_ar_q.push_back(e);
      a = a + sub * 8;
      rem = rem - sub;
      seq++;
    end
  endtask

  always @(negedge clock) begin : mon_a
    ar_t got;
    bit fin;
    if (rst) begin
      exp_ar_q.delete(); issued_a_q.delete(); burst_q.delete();
      beat_cnt = 0; outst = 0; model_err = 0; mar_pending = 0; prev_stall_a = 0;
    end else begin
      check("err_rlast", err_a, model_err);
      check("m_arsize", arsize_a, 3);
      check("m_rready", m_a.rready, s_a.rready);
      if (prev_stall_a) check("arvalid_hold", m_a.arvalid, 1);
      prev_stall_a = m_a.arvalid && !m_a.arready;
      if (m_a.arvalid) begin
        if (mar_pending) begin t_mar = cyc; mar_pending = 0; end
        if (exp_ar_q.size() == 0) check("ar_unexpected", m_a.arvalid, 0);
        else begin
          check("m_araddr", m_a.araddr, exp_ar_q[0].addr);
          check("m_arlen", m_a.arlen, exp_ar_q[0].len);
          check("m_arid", m_a.arid, exp_ar_q[0].id);
          if (m_a.arready) begin
            got.addr = m_a.araddr; got.len = m_a.arlen; got.id = m_a.arid;
            issued_a_q.push_back(got); log_a.push_back(got);
            void'(exp_ar_q.pop_front());
            outst++;
          end
        end
      end
      if (s_a.arvalid && s_a.arready) begin
        model_split(s_a.arid, s_a.araddr, int'(s_a.arlen));
        burst_q.push_back('{s_a.arid, int'(s_a.arlen) + 1});
        t_sar = cyc; mar_pending = 1;
      end
      if (m_a.rvalid) begin
        fin = (burst_q.size() > 0) && (beat_cnt + 1 == burst_q[0].beats);
        check("s_rvalid", s_a.rvalid, 1);
        check("s_rdata", s_a.rdata, m_a.rdata);
        check("s_rresp", s_a.rresp, m_a.rresp);
        check("s_rid", s_a.rid, (burst_q.size() > 0) ? burst_q[0].id : m_a.rid[7:4]);
        check("s_rlast", s_a.rlast, m_a.rlast && fin);
        if (s_a.rready) begin
          rbeats_a++;
          if (s_a.rlast) begin rlast_cnt_a++; rlast_at_a = rbeats_a; rlast_id_a = s_a.rid; end
          if (m_a.rlast) begin
            if (outst == 0) model_err = 1;
            else outst--;
          end
          if (burst_q.size() > 0) begin
            beat_cnt++;
            if (beat_cnt == burst_q[0].beats) begin void'(burst_q.pop_front()); beat_cnt = 0; end
          end
        end
      end else check("s_rvalid_idle", s_a.rvalid, 0);
    end
  end

  always @(negedge clock) begin : mon_b
    ar_t got;
    if (rst) issued_b_q.delete();
    else begin
      if (m_b.arvalid && m_b.arready) begin
        got.addr = m_b.araddr; got.len = m_b.arlen; got.id = m_b.arid;
        issued_b_q.push_back(got); log_b.push_back(got);
      end
      if (m_b.rvalid && s_b.rready && s_b.rlast) rlast_cnt_b++;
    end
  end

  task automatic send_ar_a(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    @(posedge clock); #1;
    s_a.arvalid = 1; s_a.arid = id; s_a.araddr = addr; s_a.arlen = len;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (s_a.arready) begin @(posedge clock); #1; s_a.arvalid = 0; return; end
    end
    check("s_ar_a_timeout", 0, 1);
    s_a.arvalid = 0;
  endtask

  task automatic send_ar_b(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    @(posedge clock); #1;
    s_b.arvalid = 1; s_b.arid = id; s_b.araddr = addr; s_b.arlen = len;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (s_b.arready) begin @(posedge clock); #1; s_b.arvalid = 0; return; end
    end
    check("s_ar_b_timeout", 0, 1);
    s_b.arvalid = 0;
  endtask

  task automatic wait_log_a(input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (log_a.size() >= n) return;
    end
    check("wait_log_a_timeout", log_a.size(), n);
  endtask

  task automatic wait_log_b(input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (log_b.size() >= n) return;
    end
    check("wait_log_b_timeout", log_b.size(), n);
  endtask

  task automatic send_sub_a();
    ar_t e;
    for (int i = 0; i < 200 && issued_a_q.size() == 0; i++) @(negedge clock);
    if (issued_a_q.size() == 0) begin check("sub_a_timeout", 0, 1); return; end
    e = issued_a_q.pop_front();
    for (int b = 0; b <= int'(e.len); b++) begin
      @(posedge clock); #1;
      m_a.rvalid = 1; m_a.rid = e.id; m_a.rresp = 2'(b);
      m_a.rdata = {e.addr, 32'(b)} ^ 64'hA5A5_0000_0000_5A5A;
      m_a.rlast = (b == int'(e.len));
    end
    @(posedge clock); #1;
    m_a.rvalid = 0; m_a.rlast = 0;
  endtask

  task automatic send_sub_b();
    ar_t e;
    for (int i = 0; i < 200 && issued_b_q.size() == 0; i++) @(negedge clock);
    if (issued_b_q.size() == 0) begin check("sub_b_timeout", 0, 1); return; end
    e = issued_b_q.pop_front();
    for (int b = 0; b <= int'(e.len); b++) begin
      @(posedge clock); #1;
      m_b.rvalid = 1; m_b.rid = e.id; m_b.rresp = 2'b00;
      m_b.rdata = {e.addr, 32'(b)};
      m_b.rlast = (b == int'(e.len));
    end
    @(posedge clock); #1;
    m_b.rvalid = 0; m_b.rlast = 0;
  endtask

  task automatic clear_a_stats();
    log_a.delete(); rbeats_a = 0; rlast_cnt_a = 0; rlast_at_a = 0;
  endtask

  task automatic run_t2();
    clear_a_stats();
    send_ar_a(4'd5, 32'h2000, 8'd9);
    wait_log_a(1);
    if (log_a.size() >= 1) begin
      check("t2_addr", log_a[0].addr, 32'h2000);
      check("t2_len", log_a[0].len, 9);
      check("t2_id", log_a[0].id, 8'h50);
    end
    check("t2_latency", t_mar - t_sar, 2);
    send_sub_a();
    repeat (2) @(negedge clock);
    check("t2_rlast_cnt", rlast_cnt_a, 1);
    check("t2_rlast_beat", rlast_at_a, 10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] t1_addr [4];
    t1_addr[0] = 32'h1000; t1_addr[1] = 32'h1080; t1_addr[2] = 32'h1100; t1_addr[3] = 32'h1180;
    s_a.arvalid = 0; s_a.arid = '0; s_a.araddr = '0; s_a.arlen = '0; s_a.rready = 1;
    s_b.arvalid = 0; s_b.arid = '0; s_b.araddr = '0; s_b.arlen = '0; s_b.rready = 1;
    m_a.arready = 1; m_a.rvalid = 0; m_a.rid = '0; m_a.rdata = '0; m_a.rresp = '0; m_a.rlast = 0;
    m_b.arready = 1; m_b.rvalid = 0; m_b.rid = '0; m_b.rdata = '0; m_b.rresp = '0; m_b.rlast = 0;
    repeat (3) @(posedge clock);
    #1 rst = 0;

    // Reset state
    check("rst_s_arready_first", s_a.arready, 0);
    check("rst_m_arvalid", m_a.arvalid, 0);
    check("rst_m_araddr", m_a.araddr, 0);
    check("rst_m_arlen", m_a.arlen, 0);
    check("rst_m_arid", m_a.arid, 0);
    check("rst_err", err_a, 0);
    @(posedge clock); #1;
    check("rst_s_arready_after", s_a.arready, 1);

    // T1: 64 beats -> four 16-beat sub-bursts, single s_rlast
    clear_a_stats();
    send_ar_a(4'd3, 32'h1000, 8'd63);
    wait_log_a(4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      check("t1_addr", log_a[i].addr, t1_addr[i]);
      check("t1_len", log_a[i].len, 15);
      check("t1_id", log_a[i].id, 8'h30 + 8'(i));
    end
    repeat (4) send_sub_a();
    repeat (2) @(negedge clock);
    check("t1_rlast_cnt", rlast_cnt_a, 1);
    check("t1_rlast_beat", rlast_at_a, 64);
    check("t1_rlast_id", rlast_id_a, 3);

    // T2
    run_t2();

    // T3: 4KB split
    clear_a_stats();
    send_ar_a(4'd6, 32'h0FC0, 8'd15);
    wait_log_a(2);
    if (log_a.size() >= 2) begin
      check("t3_addr0", log_a[0].addr, 32'h0FC0);
      check("t3_len0", log_a[0].len, 7);
      check("t3_id0", log_a[0].id, 8'h60);
      check("t3_addr1", log_a[1].addr, 32'h1000);
      check("t3_len1", log_a[1].len, 7);
      check("t3_id1", log_a[1].id, 8'h61);
    end
    repeat (2) send_sub_a();
    repeat (2) @(negedge clock);
    check("t3_rlast_beat", rlast_at_a, 16);

    // T3 with SPLIT_4K=0 (dut_b)
    send_ar_b(4'd6, 32'h0FC0, 8'd15);
    wait_log_b(1);
    repeat (6) @(negedge clock);
    check("t3b_count", log_b.size(), 1);
    if (log_b.size() >= 1) begin
      check("t3b_addr", log_b[0].addr, 32'h0FC0);
      check("t3b_len", log_b[0].len, 15);
      check("t3b_id", log_b[0].id, 8'h60);
    end
    send_sub_b();
    repeat (2) @(negedge clock);
    check("t3b_rlast_cnt", rlast_cnt_b, 1);

    // T4: OUTSTANDING=2 stall (dut_b)
    log_b.delete(); rlast_cnt_b = 0;
    send_ar_b(4'd2, 32'h0, 8'd63);
    wait_log_b(2);
    repeat (15) @(negedge clock);
    check("t4_stall_count", log_b.size(), 2);
    check("t4_stall_arvalid", m_b.arvalid, 0);
    send_sub_b();
    wait_log_b(3);
    check("t4_third_count", log_b.size(), 3);
    if (log_b.size() >= 3) check("t4_third_addr", log_b[2].addr, 32'h100);
    repeat (3) send_sub_b();
    repeat (2) @(negedge clock);
    check("t4_total_ars", log_b.size(), 4);
    check("t4_rlast_cnt", rlast_cnt_b, 1);
    check("t4_err", err_b, 0);

    // rready pass-through with the slave applying backpressure while idle
    @(posedge clock); #1 s_a.rready = 0;
    @(negedge clock);
    check("rready_low", m_a.rready, 0);
    @(posedge clock); #1 s_a.rready = 1;

    // T6: stray master rlast
    @(posedge clock); #1;
    m_a.rvalid = 1; m_a.rlast = 1; m_a.rid = 8'h5A; m_a.rdata = 64'h0123_4567_89AB_CDEF; m_a.rresp = 2'b10;
    @(negedge clock);
    check("t6_s_rlast", s_a.rlast, 0);
    check("t6_s_rid", s_a.rid, 4'h5);
    @(posedge clock); #1;
    m_a.rvalid = 0; m_a.rlast = 0;
    @(negedge clock);
    check("t6_err_set", err_a, 1);
    repeat (3) @(negedge clock);
    check("t6_err_held", err_a, 1);

    // T5: reset while stuck in ISSUE
    m_a.arready = 0;
    send_ar_a(4'd2, 32'h3000, 8'd9);
    for (int i = 0; i < 20 && !m_a.arvalid; i++) @(negedge clock);
    check("t5_in_issue", m_a.arvalid, 1);
    repeat (5) @(negedge clock);
    check("t5_hold", m_a.arvalid, 1);
    @(posedge clock); #1 rst = 1;
    #1;
    check("t5_rst_arvalid", m_a.arvalid, 0);
    check("t5_rst_arready", s_a.arready, 0);
    check("t5_rst_err", err_a, 0);
    @(posedge clock); #1;
    rst = 0; m_a.arready = 1;
    check("t5_first_cycle_arready", s_a.arready, 0);
    run_t2();

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
